// File: rtl/seq_div.sv
// Sequential signed 32-bit divider: magnitude restoring division over 32 cycles,
// then a sign-fix cycle and a one-cycle done pulse. Divide-by-zero completes immediately.
module seq_div (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic [1:0]  dbg_state
);

  // Handshake: start is a request sampled only while busy=0 (IDLE); the edge
  // that samples start=1 in IDLE accepts the operands. done pulses for one
  // cycle when results are valid; busy stays high from acceptance through done.

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [32:0] dmag_q, dmag_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] remo_q, remo_d;
  logic        dz_q, dz_d;

  logic [32:0] dvd_mag;
  logic [32:0] dvs_mag;
  logic [33:0] shifted;
  logic [33:0] trial;
  logic        ge;

  always_comb begin
    // 33-bit magnitudes so that -2^31 becomes +2^31 without overflow
    dvd_mag = dividend[31] ? (33'd0 - {dividend[31], dividend}) : {1'b0, dividend};
    dvs_mag = divisor[31]  ? (33'd0 - {divisor[31], divisor})   : {1'b0, divisor};
    shifted = {rem_q, quo_q[31]};
    trial   = shifted - {1'b0, dmag_q};
    ge      = ~trial[33];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dmag_d  = dmag_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == 32'd0) begin
            quot_d  = 32'hFFFF_FFFF;
            remo_d  = dividend;
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            // {rem,quo} starts as the 65-bit zero-extended dividend magnitude
            rem_d   = {32'd0, dvd_mag[32]};
            quo_d   = dvd_mag[31:0];
            dmag_d  = dvs_mag;
            qneg_d  = dividend[31] ^ divisor[31];
            rneg_d  = dividend[31];
            cnt_d   = 6'd0;
            dz_d    = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = ge ? trial[32:0] : shifted[32:0];
        quo_d = {quo_q[30:0], ge};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = FIX;
        end
      end
      FIX: begin
        quot_d  = qneg_q ? (32'd0 - quo_q) : quo_q;
        remo_d  = rneg_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      rem_q   <= 33'd0;
      quo_q   <= 32'd0;
      dmag_q  <= 33'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quot_q  <= 32'd0;
      remo_q  <= 32'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dmag_q  <= dmag_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dz_q    <= dz_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign div_zero  = dz_q;
  assign quotient  = quot_q;
  assign remainder = remo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div: fixed vector table, reset/abort and back-to-back sequences,
// and randomized operations checked against a plain-arithmetic division model.
module tb_seq_div;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vt[12];

  seq_div dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .quotient  (quotient),
    .remainder (remainder),
    .dbg_state (dbg_state)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Signed division truncating toward zero; remainder carries the dividend's sign.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz);
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = a;
      dz = 1'b1;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
      dz = 1'b0;
    end
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issues one operation from IDLE; returns the done-cycle outputs and the latency
  // in cycles after the accepting edge. With noise, start/operands toggle while busy.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit noise,
                        output logic [31:0] q, output logic [31:0] r,
                        output logic dz, output int lat);
    logic [31:0] q_before;
    logic [31:0] r_before;
    int bad;
    bad      = 0;
    q_before = quotient;
    r_before = remainder;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    step();
    start = 1'b0;
    lat   = -1;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (busy !== 1'b1 || quotient !== q_before || remainder !== r_before) bad++;
      if (noise) begin
        start    = 1'($urandom_range(0, 1));
        dividend = $urandom;
        divisor  = $urandom;
      end
      step();
    end
    q  = quotient;
    r  = remainder;
    dz = div_zero;
    check("busy_in_done", busy, 1);
    check("busy_and_hold_during_run", bad, 0);
    if (noise) begin
      start    = 1'b1;
      dividend = $urandom;
      divisor  = $urandom_range(0, 3);
    end
    step();
    start = 1'b0;
    check("done_one_cycle", done, 0);
    check("busy_low_after_done", busy, 0);
  endtask

  task automatic apply_model(input string name, input logic [31:0] a, input logic [31:0] b,
                             input bit noise);
    logic [31:0] eq, er, q, r;
    logic        edz, dz;
    int          lat;
    ref_div(a, b, eq, er, edz);
    run_op(a, b, noise, q, r, dz, lat);
    check({name, "_latency"}, lat, (b == 32'd0) ? 1 : 34);
    check({name, "_quotient"}, q, eq);
    check({name, "_remainder"}, r, er);
    check({name, "_div_zero"}, dz, edz);
  endtask

  initial begin
    logic [31:0] q, r;
    logic        dz;
    logic [31:0] a, b;
    int          lat, saw_done, pulses, bad;

    vt[0]  = '{32'd7,         32'd2,         32'd3,         32'd1,         1'b0};
    vt[1]  = '{32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vt[2]  = '{32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0};
    vt[3]  = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 1'b0};
    vt[4]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0};
    vt[5]  = '{32'h8000_0000, 32'd1,         32'h8000_0000, 32'd0,         1'b0};
    vt[6]  = '{32'd100,       32'd0,         32'hFFFF_FFFF, 32'd100,       1'b1};
    vt[7]  = '{32'd9,         32'd3,         32'd3,         32'd0,         1'b0};
    vt[8]  = '{32'd1000,      32'd7,         32'd142,       32'd6,         1'b0};
    vt[9]  = '{32'd0,         32'd5,         32'd0,         32'd0,         1'b0};
    vt[10] = '{32'd5,         32'h8000_0000, 32'd0,         32'd5,         1'b0};
    vt[11] = '{32'h8000_0000, 32'h8000_0000, 32'd1,         32'd0,         1'b0};

    reset    = 1'b0;
    start    = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_div_zero", div_zero, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    reset = 1'b1;
    step();

    for (int i = 0; i < 12; i++) begin
      run_op(vt[i].a, vt[i].b, 1'b0, q, r, dz, lat);
      check($sformatf("vec%0d_latency", i), lat, (vt[i].b == 32'd0) ? 1 : 34);
      check($sformatf("vec%0d_quotient", i), q, vt[i].q);
      check($sformatf("vec%0d_remainder", i), r, vt[i].r);
      check($sformatf("vec%0d_div_zero", i), dz, vt[i].dz);
    end

    // Abort mid-operation with reset; a start pulse at cycle 10 must be ignored.
    saw_done = 0;
    start    = 1'b1;
    dividend = 32'd1000;
    divisor  = 32'd7;
    step();
    start = 1'b0;
    for (int k = 1; k < 20; k++) begin
      if (done) saw_done = 1;
      start    = (k == 10);
      dividend = (k == 10) ? 32'd5 : 32'd1000;
      divisor  = (k == 10) ? 32'd5 : 32'd7;
      step();
    end
    start = 1'b0;
    if (done) saw_done = 1;
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("abort_no_done", saw_done, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_div_zero", div_zero, 0);
    step();
    check("abort_still_idle", busy, 0);
    apply_model("after_abort", 32'd1000, 32'd7, 1'b0);

    // Reset wins over start on the same edge.
    reset    = 1'b0;
    start    = 1'b1;
    dividend = 32'd7;
    divisor  = 32'd2;
    step();
    reset = 1'b1;
    start = 1'b0;
    check("rst_priority_busy", busy, 0);
    step();
    check("rst_priority_idle", busy, 0);

    // Back-to-back with start held high: done at cycles 34, 69, 104.
    pulses   = 0;
    bad      = 0;
    start    = 1'b1;
    dividend = 32'd1000;
    divisor  = 32'd7;
    step();
    for (int k = 1; k <= 110; k++) begin
      if (done) begin
        check("b2b_pulse_cycle", k, 34 + 35 * pulses);
        pulses++;
      end
      if (pulses > 0 && (quotient !== 32'd142 || remainder !== 32'd6)) bad++;
      step();
    end
    start = 1'b0;
    check("b2b_pulse_count", pulses, 3);
    check("b2b_results_stable", bad, 0);
    for (int k = 0; k < 40 && busy; k++) step();
    check("b2b_back_idle", busy, 0);

    // Randomized operations with busy-time start noise.
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFF_FFFF;
        3:       b = $urandom_range(2, 20);
        4:       b = 32'd0 - $urandom_range(2, 20);
        default: b = $urandom;
      endcase
      apply_model($sformatf("rand%0d", i), a, b, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits.
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (sampled on the rising edge of clock; 0 = reset).
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 dividend  input  32  signed two's-complement dividend; captured on the accepting edge.
REQ-006 divisor  input  32  signed two's-complement divisor; captured on the accepting edge.
REQ-007 busy  output  1  high from the accepting edge until done deasserts.
REQ-008 done  output  1  one-cycle pulse; quotient/remainder/div_zero valid from this cycle on.
REQ-009 div_zero  output  1  divisor was zero for the completed operation.
REQ-010 quotient  output  32  signed quotient (goes to LO).
REQ-011 remainder  output  32  signed remainder (goes to HI).

Function
REQ-012 The FSM SHALL have states IDLE, RUN, FIX, DONE.
REQ-013 IDLE with start=1 and divisor!=0 SHALL capture the operands, take their magnitudes, record the signs, clear the 6-bit counter and go to RUN.
REQ-014 IDLE with start=1 and divisor=0 SHALL go directly to DONE with quotient=32'hFFFFFFFF, remainder=dividend and div_zero=1.
REQ-015 RUN SHALL do one unsigned restoring-division step per cycle: shift {rem,quo} left 1, trial-subtract the divisor magnitude from the 33-bit partial remainder, keep the result and set the quotient LSB if it is non-negative. RUN SHALL last exactly 32 cycles.
REQ-016 FIX SHALL negate the quotient if the operand signs differ and negate the remainder if the dividend was negative (truncation toward zero; the remainder takes the dividend's sign). It SHALL last 1 cycle.
REQ-017 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-018 Latency for a non-zero divisor SHALL be fixed: done high in the 34th cycle after the accepting edge (32 RUN + 1 FIX + 1 DONE). For a zero divisor, done SHALL be high in the 1st cycle after the accepting edge.
REQ-019 busy SHALL be 1 in RUN, FIX and DONE, and 0 in IDLE.
REQ-020 start while busy=1 SHALL be ignored: no queueing, no effect on the result. start in the DONE cycle SHALL be ignored.
REQ-021 quotient, remainder and div_zero SHALL hold their last completed values while in IDLE, until the next done. Intermediate values SHALL NOT be visible on them during RUN/FIX.
REQ-022 -2147483648 / -1 SHALL yield quotient=32'h80000000 and remainder=0 (two's-complement wrap), with div_zero=0.
REQ-023 A dividend of 32'h80000000 SHALL have magnitude 2^31 handled without loss, using 33-bit internal magnitude arithmetic.
REQ-024 div_zero SHALL be cleared at the next accepted start with a non-zero divisor.

Reset
REQ-025 reset=0 at a rising edge SHALL force IDLE, counter=0, busy=0, done=0, div_zero=0, quotient=0, remainder=0.
REQ-026 reset asserted mid-operation SHALL abort it with no done pulse. The first start after reset releases SHALL be accepted normally.
REQ-027 reset SHALL take priority over start on the same edge.

Verification
REQ-028 7 / 2 -> after 34 cycles: done=1, quotient=3, remainder=1, div_zero=0.
REQ-029 -7 / 2 -> quotient=32'hFFFFFFFD, remainder=32'hFFFFFFFF. 7 / -2 -> quotient=32'hFFFFFFFD, remainder=1. -7 / -2 -> quotient=3, remainder=32'hFFFFFFFF.
REQ-030 32'h80000000 / 32'hFFFFFFFF -> quotient=32'h80000000, remainder=0. 32'h80000000 / 1 -> quotient=32'h80000000, remainder=0.
REQ-031 100 / 0 -> done one cycle later, div_zero=1, quotient=32'hFFFFFFFF, remainder=100. The next 9 / 3 -> quotient=3, remainder=0, div_zero=0.
REQ-032 Start 1000 / 7, pulse start with 5 / 5 at cycle 10, assert reset=0 at cycle 20 for 1 cycle -> no done, busy=0 and outputs all 0 after reset. A new 1000 / 7 -> quotient=142, remainder=6 after 34 cycles.
REQ-033 Back-to-back: start held high continuously with 1000 / 7 -> ops accepted every 35 cycles, done pulses exactly 1 cycle wide, results stable between pulses.
